// File: rtl/countdown_ctrl_pkg.sv
// ============================================================================
// countdown_ctrl_pkg : shared state, edit-field and BCD constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package countdown_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_STOP    = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_RUN     = 3'd4,
        ST_ALARM   = 3'd5
    } state_t;

    localparam logic [1:0] EDIT_NONE = 2'd0;
    localparam logic [1:0] EDIT_HR   = 2'd1;
    localparam logic [1:0] EDIT_MIN  = 2'd2;
    localparam logic [1:0] EDIT_SEC  = 2'd3;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_11 = 8'h11;
    localparam logic [7:0] BCD_59 = 8'h59;

endpackage

`default_nettype wire

// File: rtl/countdown_ctrl_bcd2_inc.sv
// ============================================================================
// bcd2_inc : combinational two-digit BCD +1 that wraps to 00 at WRAP
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd2_inc
    import countdown_ctrl_pkg::*;
#(
    parameter logic [7:0] WRAP = 8'h59
) (
    input  logic [7:0] value,
    output logic [7:0] next_value
);

    // Wrap test comes first so e.g. 59 never carries into an illegal 60.
    always_comb begin
        if (value == WRAP) begin
            next_value = BCD_00;
        end else if (value[3:0] == 4'd9) begin
            next_value = {value[7:4] + 4'd1, 4'd0};
        end else begin
            next_value = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/countdown_ctrl.sv
// ============================================================================
// countdown_ctrl : run/pause/set/alarm sequencer for the hh:mm:ss countdown
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module countdown_ctrl
    import countdown_ctrl_pkg::*;
#(
    parameter int         ALARM_SECS = 10,
    parameter logic [7:0] HR_MAX     = 8'h11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       zero_flag,
    output logic       run_en,
    output logic       load,
    output logic [7:0] load_hr,
    output logic [7:0] load_min,
    output logic [7:0] load_sec,
    output logic [1:0] edit_field,
    output logic       alarm
);

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);

    logic [1:0] mode_sync, inc_sync;
    logic       mode_prev, inc_prev;
    logic       mode_p, inc_p;
    state_t     state, state_next;
    logic [3:0] alarm_cnt, alarm_cnt_next;
    logic       load_next;
    logic [7:0] hr_next, min_next, sec_next;
    logic [7:0] hr_inc, min_inc, sec_inc;

    bcd2_inc #(.WRAP(HR_MAX)) u_hr_inc  (.value(load_hr),  .next_value(hr_inc));
    bcd2_inc #(.WRAP(BCD_59)) u_min_inc (.value(load_min), .next_value(min_inc));
    bcd2_inc #(.WRAP(BCD_59)) u_sec_inc (.value(load_sec), .next_value(sec_inc));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_sync <= 2'b00;
            inc_sync  <= 2'b00;
            mode_prev <= 1'b0;
            inc_prev  <= 1'b0;
        end else begin
            mode_sync <= {mode_sync[0], btn_mode};
            inc_sync  <= {inc_sync[0], btn_inc};
            mode_prev <= mode_sync[1];
            inc_prev  <= inc_sync[1];
        end
    end

    assign mode_p = mode_sync[1] & ~mode_prev;
    assign inc_p  = inc_sync[1] & ~inc_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_STOP;
            alarm_cnt <= 4'd0;
            load      <= 1'b0;
            load_hr   <= BCD_11;
            load_min  <= BCD_59;
            load_sec  <= BCD_59;
        end else begin
            state     <= state_next;
            alarm_cnt <= alarm_cnt_next;
            load      <= load_next;
            load_hr   <= hr_next;
            load_min  <= min_next;
            load_sec  <= sec_next;
        end
    end

    // Every branch tests mode_p first, so a coincident inc_p is dropped.
    always_comb begin
        state_next     = state;
        alarm_cnt_next = alarm_cnt;
        load_next      = 1'b0;
        hr_next        = load_hr;
        min_next       = load_min;
        sec_next       = load_sec;
        case (state)
            ST_STOP: begin
                if (mode_p)     state_next = ST_SET_HR;
                else if (inc_p) state_next = ST_RUN;
            end
            ST_SET_HR: begin
                if (mode_p)     state_next = ST_SET_MIN;
                else if (inc_p) hr_next    = hr_inc;
            end
            ST_SET_MIN: begin
                if (mode_p)     state_next = ST_SET_SEC;
                else if (inc_p) min_next   = min_inc;
            end
            ST_SET_SEC: begin
                if (mode_p) begin
                    state_next = ST_STOP;
                    load_next  = 1'b1;
                end else if (inc_p) begin
                    sec_next = sec_inc;
                end
            end
            ST_RUN: begin
                if (mode_p) begin
                    state_next = ST_STOP;
                end else if (tick && zero_flag) begin
                    state_next     = ST_ALARM;
                    alarm_cnt_next = 4'd0;
                end
            end
            ST_ALARM: begin
                if (mode_p || inc_p) begin
                    state_next = ST_STOP;
                    load_next  = 1'b1;
                end else if (tick) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_next = ST_STOP;
                        load_next  = 1'b1;
                    end else begin
                        alarm_cnt_next = alarm_cnt + 4'd1;
                    end
                end
            end
            default: state_next = ST_STOP;
        endcase
    end

    // run_en is combinational on zero_flag so the counters stop at 00:00:00.
    always_comb begin
        run_en = (state == ST_RUN) && !zero_flag;
        alarm  = (state == ST_ALARM);
        case (state)
            ST_SET_HR:  edit_field = EDIT_HR;
            ST_SET_MIN: edit_field = EDIT_MIN;
            ST_SET_SEC: edit_field = EDIT_SEC;
            default:    edit_field = EDIT_NONE;
        endcase
    end

endmodule

`default_nettype wire
